// File: rtl/regfile_wb_arb_pkg.sv
// Shared regfile defines: index/width constants, writeback grant type and the
// hardwired-register test used by the writeback arbiter.
package regfile_wb_arb_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  localparam logic [REG_AW-1:0] R_ZERO = 5'd0;
  localparam logic [REG_AW-1:0] R_ONE  = 5'd1;
  localparam logic [REG_AW-1:0] R_PC   = 5'd31;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_ALU  = 2'd1,
    GRANT_LSU  = 2'd2
  } grant_e;

  // Registers whose value is fixed in the regfile; writes to them are discarded.
  function automatic logic is_hardwired(input logic [REG_AW-1:0] addr);
    return (addr == R_ZERO) || (addr == R_ONE) || (addr == R_PC);
  endfunction

endpackage

// File: rtl/regfile_wb_arb_wb_skid1.sv
// wb_skid1: one-entry skid buffer holding a single pending LSU writeback.
// A load in the same cycle as a drain replaces the entry with no empty cycle.
module wb_skid1
  import regfile_wb_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_drain,
  input  logic [REG_AW-1:0] i_addr,
  input  logic [REG_DW-1:0] i_data,
  output logic              o_full,
  output logic [REG_AW-1:0] o_addr,
  output logic [REG_DW-1:0] o_data
);

  logic              r_full;
  logic [REG_AW-1:0] r_addr;
  logic [REG_DW-1:0] r_data;

  // NOTE: state is updated with <= so every flop samples pre-edge values; a
  // blocking = here would let later statements see this cycle's new value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= 1'b0;
      // NOTE: the payload is only meaningful while r_full is set, so its reset
      // is not functionally needed; it is cleared anyway for deterministic X-free output.
      r_addr <= '0;
      r_data <= '0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_addr <= i_addr;
      r_data <= i_data;
    end else if (i_drain) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_addr = r_addr;
  assign o_data = r_data;

endmodule

// File: rtl/regfile_wb_arb.sv
// regfile_wb_arb: shares the regfile write port between ALU and LSU writebacks.
// Define WB_ARB_STARVE_GUARD_EN to bound how many cycles a buffered LSU write can lose.
module regfile_wb_arb
  import regfile_wb_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_addr,
  input  logic [REG_DW-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [REG_AW-1:0] lsu_addr,
  input  logic [REG_DW-1:0] lsu_data,
  output logic              lsu_ready,
  output logic              we,
  output logic [REG_AW-1:0] addrw,
  output logic [REG_DW-1:0] wdata,
  output logic              lsu_pend,
  output logic              drop
);

  logic              w_buf_full;
  logic [REG_AW-1:0] w_buf_addr;
  logic [REG_DW-1:0] w_buf_data;
  logic              w_starve;
  logic              w_drain;
  logic              w_lsu_accept;
  logic              w_win_valid;
  logic              w_win_drop;
  logic [REG_AW-1:0] w_win_addr;
  logic [REG_DW-1:0] w_win_data;
  grant_e            w_grant;

  logic              r_we;
  logic              r_drop;
  logic [REG_AW-1:0] r_addrw;
  logic [REG_DW-1:0] r_wdata;

  always_comb begin
    // NOTE: default first, so no path through the block leaves w_grant unassigned
    // (which would infer a latch).
    w_grant = GRANT_NONE;
    if (alu_valid && !w_starve) begin
      w_grant = GRANT_ALU;
    end else if (w_buf_full) begin
      w_grant = GRANT_LSU;
    end
  end

  assign w_drain      = (w_grant == GRANT_LSU);
  assign alu_ready    = !(w_starve && w_buf_full);
  assign lsu_ready    = !w_buf_full || w_drain;
  assign w_lsu_accept = lsu_valid && lsu_ready;

  assign w_win_valid  = (w_grant != GRANT_NONE);
  assign w_win_addr   = (w_grant == GRANT_ALU) ? alu_addr : w_buf_addr;
  assign w_win_data   = (w_grant == GRANT_ALU) ? alu_data : w_buf_data;
  assign w_win_drop   = is_hardwired(w_win_addr);

  wb_skid1 u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_lsu_accept),
    .i_drain (w_drain),
    .i_addr  (lsu_addr),
    .i_data  (lsu_data),
    .o_full  (w_buf_full),
    .o_addr  (w_buf_addr),
    .o_data  (w_buf_data)
  );

`ifdef WB_ARB_STARVE_GUARD_EN
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starve_cnt;

  // Counts cycles the buffered entry has lost; saturates and waits for the drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (w_drain) begin
      r_starve_cnt <= '0;
    end else if (w_buf_full && (r_starve_cnt != CNT_MAX)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign w_starve = w_buf_full && (r_starve_cnt == CNT_MAX);
`else
  // Strict ALU priority: starvation never asserts and the limit has no effect.
  assign w_starve = 1'b0 & (STARVE_LIMIT >= 0);
`endif

  // Hardwired destinations complete the handshake but raise drop instead of we;
  // the address/data registers still follow any granted write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_drop  <= 1'b0;
      r_addrw <= '0;
      r_wdata <= '0;
    end else begin
      r_we   <= w_win_valid && !w_win_drop;
      r_drop <= w_win_valid && w_win_drop;
      if (w_win_valid) begin
        r_addrw <= w_win_addr;
        r_wdata <= w_win_data;
      end
    end
  end

  assign we       = r_we;
  assign drop     = r_drop;
  assign addrw    = r_addrw;
  assign wdata    = r_wdata;
  assign lsu_pend = w_buf_full;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Self-checking bench for regfile_wb_arb: directed vector table, starvation and
// reset sequences, then randomized traffic against a behavioural reference model.
module tb_regfile_wb_arb;

  localparam int LIMIT = 4;
`ifdef WB_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        we;
  logic [4:0]  addrw;
  logic [31:0] wdata;
  logic        lsu_pend;
  logic        drop;

  regfile_wb_arb #(.STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .lsu_valid (lsu_valid),
    .lsu_addr  (lsu_addr),
    .lsu_data  (lsu_data),
    .lsu_ready (lsu_ready),
    .we        (we),
    .addrw     (addrw),
    .wdata     (wdata),
    .lsu_pend  (lsu_pend),
    .drop      (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    alu_valid = av;
    alu_addr  = aa;
    alu_data  = ad;
    lsu_valid = lv;
    lsu_addr  = la;
    lsu_data  = ld;
  endtask

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        e_ar;
    logic        e_lr;
    logic        e_we;
    logic        e_drop;
    logic        e_pend;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        chk_ad;
  } vec_t;

  function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                              input logic lv, input logic [4:0] la, input logic [31:0] ld,
                              input logic e_ar, input logic e_lr, input logic e_we,
                              input logic e_drop, input logic e_pend,
                              input logic [4:0] e_addr, input logic [31:0] e_data,
                              input logic chk_ad);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.lv = lv; v.la = la; v.ld = ld;
    v.e_ar = e_ar; v.e_lr = e_lr; v.e_we = e_we; v.e_drop = e_drop; v.e_pend = e_pend;
    v.e_addr = e_addr; v.e_data = e_data; v.chk_ad = chk_ad;
    return v;
  endfunction

  vec_t tbl[17];

  // Buffers r9 alongside an ALU write, then keeps the ALU valid every cycle.
  task automatic starve_seq(input string tag);
    int n;
    logic lsu_turn;
    drive(1'b1, 5'd11, 32'h1100_0000, 1'b1, 5'd9, 32'h99);
    @(negedge clk);
    check({tag, "_first_alu_ready"}, alu_ready, 1);
    check({tag, "_first_lsu_ready"}, lsu_ready, 1);
    @(posedge clk); #1;
    check({tag, "_first_we"}, we, 1);
    check({tag, "_first_addrw"}, addrw, 11);
    check({tag, "_first_pend"}, lsu_pend, 1);
    n = GUARD ? 6 : 10;
    for (int k = 1; k <= n; k++) begin
      drive(1'b1, 5'd12, 32'(k), 1'b0, 5'd0, 32'h0);
      lsu_turn = GUARD && (k == 5);
      @(negedge clk);
      check({tag, "_alu_ready"}, alu_ready, !lsu_turn);
      check({tag, "_lsu_ready"}, lsu_ready, lsu_turn);
      @(posedge clk); #1;
      check({tag, "_we"}, we, 1);
      check({tag, "_addrw"}, addrw, lsu_turn ? 32'd9 : 32'd12);
      check({tag, "_wdata"}, wdata, lsu_turn ? 32'h99 : 32'(k));
      check({tag, "_pend"}, lsu_pend, GUARD ? (k < 5) : 1'b1);
    end
    if (!GUARD) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      @(posedge clk); #1;
      check({tag, "_late_drain_we"}, we, 1);
      check({tag, "_late_drain_addrw"}, addrw, 9);
      check({tag, "_late_drain_pend"}, lsu_pend, 0);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  // Reference model state: the pending LSU entry and how many cycles it has lost.
  logic        m_full;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_wait;

  initial begin
    tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,      1, 1, 1, 0, 0, 5, 32'hDEADBEEF, 1);
    tbl[1]  = mk(0, 0, 0,            0, 0, 0,      1, 1, 0, 0, 0, 5, 32'hDEADBEEF, 1);
    tbl[2]  = mk(0, 0, 0,            1, 7, 32'h12, 1, 1, 0, 0, 1, 5, 32'hDEADBEEF, 1);
    tbl[3]  = mk(0, 0, 0,            0, 0, 0,      1, 1, 1, 0, 0, 7, 32'h12, 1);
    tbl[4]  = mk(1, 0, 32'h1,        0, 0, 0,      1, 1, 0, 1, 0, 0, 0, 0);
    tbl[5]  = mk(1, 1, 32'h2,        0, 0, 0,      1, 1, 0, 1, 0, 0, 0, 0);
    tbl[6]  = mk(1, 31, 32'h3,       0, 0, 0,      1, 1, 0, 1, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0,            0, 0, 0,      1, 1, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0,            1, 2, 32'hA2, 1, 1, 0, 0, 1, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0,            1, 3, 32'hA3, 1, 1, 1, 0, 1, 2, 32'hA2, 1);
    tbl[10] = mk(0, 0, 0,            0, 0, 0,      1, 1, 1, 0, 0, 3, 32'hA3, 1);
    tbl[11] = mk(1, 8, 32'h80,       1, 8, 32'h88, 1, 1, 1, 0, 1, 8, 32'h80, 1);
    tbl[12] = mk(0, 0, 0,            0, 0, 0,      1, 1, 1, 0, 0, 8, 32'h88, 1);
    tbl[13] = mk(1, 4, 32'h44,       1, 6, 32'h66, 1, 1, 1, 0, 1, 4, 32'h44, 1);
    tbl[14] = mk(1, 10, 32'hAA,      0, 0, 0,      1, 0, 1, 0, 1, 10, 32'hAA, 1);
    tbl[15] = mk(0, 0, 0,            0, 0, 0,      1, 1, 1, 0, 0, 6, 32'h66, 1);
    tbl[16] = mk(0, 0, 0,            0, 0, 0,      1, 1, 0, 0, 0, 6, 32'h66, 1);

    // Reset state, with a request presented while reset is held.
    rst = 1'b0;
    drive(1'b1, 5'd5, 32'h5555, 1'b0, 5'd0, 32'h0);
    #2;
    check("rst_alu_ready", alu_ready, 1);
    check("rst_lsu_ready", lsu_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", we, 0);
    check("rst_drop", drop, 0);
    check("rst_pend", lsu_pend, 0);
    check("rst_addrw", addrw, 0);
    check("rst_wdata", wdata, 0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].lv, tbl[i].la, tbl[i].ld);
      @(negedge clk);
      check($sformatf("vec%0d_alu_ready", i), alu_ready, tbl[i].e_ar);
      check($sformatf("vec%0d_lsu_ready", i), lsu_ready, tbl[i].e_lr);
      @(posedge clk); #1;
      check($sformatf("vec%0d_we", i), we, tbl[i].e_we);
      check($sformatf("vec%0d_drop", i), drop, tbl[i].e_drop);
      check($sformatf("vec%0d_pend", i), lsu_pend, tbl[i].e_pend);
      if (tbl[i].chk_ad) begin
        check($sformatf("vec%0d_addrw", i), addrw, tbl[i].e_addr);
        check($sformatf("vec%0d_wdata", i), wdata, tbl[i].e_data);
      end
    end

    starve_seq("starve");

    // Reset mid-transfer with the entry buffered and three lost cycles counted.
    drive(1'b1, 5'd11, 32'h11, 1'b1, 5'd9, 32'h99);
    @(posedge clk); #1;
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 5'd12, 32'(k), 1'b0, 5'd0, 32'h0);
      @(posedge clk); #1;
    end
    check("pre_rst_pend", lsu_pend, 1);
    drive(1'b1, 5'd12, 32'h4, 1'b0, 5'd0, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_we", we, 0);
    check("midrst_drop", drop, 0);
    check("midrst_pend", lsu_pend, 0);
    check("midrst_alu_ready", alu_ready, 1);
    check("midrst_lsu_ready", lsu_ready, 1);
    check("midrst_addrw", addrw, 0);
    @(posedge clk); #1;
    check("midrst_edge_we", we, 0);
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("postrst_we", we, 0);
      check("postrst_pend", lsu_pend, 0);
    end
    starve_seq("restarve");

    // Randomized traffic against the reference model; DUT buffer is empty here.
    m_full = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_wait = 0;
    for (int n = 0; n < 1500; n++) begin
      logic        av, lv, starve, alu_win, drain, e_ar, e_lr, granted, hard;
      logic [4:0]  aa, la, w_addr;
      logic [31:0] ad, ld;
      av = ($urandom_range(0, 9) < 7);
      aa = 5'($urandom_range(0, 31));
      ad = $urandom;
      lv = 1'($urandom_range(0, 1));
      la = 5'($urandom_range(0, 31));
      ld = $urandom;
      drive(av, aa, ad, lv, la, ld);
      @(negedge clk);
      starve  = GUARD && m_full && (m_wait >= LIMIT);
      e_ar    = !(starve && m_full);
      alu_win = av && !starve;
      drain   = m_full && !alu_win;
      e_lr    = !m_full || drain;
      check("rand_alu_ready", alu_ready, e_ar);
      check("rand_lsu_ready", lsu_ready, e_lr);
      granted = alu_win || drain;
      w_addr  = alu_win ? aa : m_addr;
      hard    = (w_addr == 5'd0) || (w_addr == 5'd1) || (w_addr == 5'd31);
      @(posedge clk); #1;
      check("rand_we", we, granted && !hard);
      check("rand_drop", drop, granted && hard);
      if (granted && !hard) begin
        check("rand_addrw", addrw, w_addr);
        check("rand_wdata", wdata, alu_win ? ad : m_data);
      end
      if (drain) m_wait = 0;
      else if (m_full) m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
      if (lv && e_lr) begin
        m_full = 1'b1;
        m_addr = la;
        m_data = ld;
      end else if (drain) begin
        m_full = 1'b0;
      end
      check("rand_pend", lsu_pend, m_full);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
